// File: rtl/fft_butterfly_pipe.sv
// fft_butterfly_pipe: 3-stage radix-2 complex butterfly on a valid/ready stream.
// Define FFT_BUTTERFLY_SAT_EN to clamp overflowing outputs; default wraps.
module fft_butterfly_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TW_FRAC    = DATA_WIDTH/2-1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x_N,
    input  logic [DATA_WIDTH-1:0] x_M,
    input  logic [DATA_WIDTH-1:0] w_N,
    input  logic                  scale,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] y_N,
    output logic [DATA_WIDTH-1:0] y_M,
    output logic                  ovf,
    input  logic                  ovf_clr
);
    localparam int H  = DATA_WIDTH/2;
    localparam int PW = 2*H+1;
    localparam int SW = PW+1;
    localparam logic signed [PW-1:0] RND =
        {{(PW-1){1'b0}}, 1'b1} << (TW_FRAC-1);

    logic                  adv;
    logic                  v1_q, v2_q, v3_q;
    logic                  sc1_q, sc2_q;
    logic [DATA_WIDTH-1:0] xn1_q, xm1_q, w1_q, xn2_q;
    logic signed [PW-1:0]  wr, wi, xr, xi;
    logic signed [PW-1:0]  pr_d, pi_d, pr_q, pi_q;
    logic signed [SW-1:0]  ar, ai, br, bi;
    logic [H:0]            f0, f1, f2, f3;
    logic [DATA_WIDTH-1:0] yn_d, ym_d, yn_q, ym_q;
    logic                  hit;
    logic                  ovf_q;

    function automatic logic signed [PW-1:0] sx(input logic [H-1:0] v);
        return {{(PW-H){v[H-1]}}, v};
    endfunction

    // Optional halving, then narrow to H bits; MSB of result is overflow.
    function automatic logic [H:0] fit(input logic signed [SW-1:0] v,
                                       input logic sc);
        logic signed [SW-1:0] s;
        logic                 o;
        logic [H-1:0]         r;
        s = sc ? (v >>> 1) : v;
        o = (s != {{(SW-H){s[H-1]}}, s[H-1:0]});
`ifdef FFT_BUTTERFLY_SAT_EN
        if (o)
            r = s[SW-1] ? {1'b1, {(H-1){1'b0}}} : {1'b0, {(H-1){1'b1}}};
        else
            r = s[H-1:0];
`else
        r = s[H-1:0];
`endif
        return {o, r};
    endfunction

    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign y_N       = yn_q;
    assign y_M       = ym_q;
    assign ovf       = ovf_q;

    assign wr   = sx(w1_q[DATA_WIDTH-1:H]);
    assign wi   = sx(w1_q[H-1:0]);
    assign xr   = sx(xm1_q[DATA_WIDTH-1:H]);
    assign xi   = sx(xm1_q[H-1:0]);
    assign pr_d = (wr*xr - wi*xi + RND) >>> TW_FRAC;
    assign pi_d = (wr*xi + wi*xr + RND) >>> TW_FRAC;

    assign ar   = {{(SW-H){xn2_q[DATA_WIDTH-1]}}, xn2_q[DATA_WIDTH-1:H]};
    assign ai   = {{(SW-H){xn2_q[H-1]}}, xn2_q[H-1:0]};
    assign br   = {pr_q[PW-1], pr_q};
    assign bi   = {pi_q[PW-1], pi_q};
    assign f0   = fit(ar + br, sc2_q);
    assign f1   = fit(ai + bi, sc2_q);
    assign f2   = fit(ar - br, sc2_q);
    assign f3   = fit(ai - bi, sc2_q);
    assign yn_d = {f0[H-1:0], f1[H-1:0]};
    assign ym_d = {f2[H-1:0], f3[H-1:0]};
    assign hit  = v2_q & (f0[H] | f1[H] | f2[H] | f3[H]);

    // Stage 1: register the accepted operand beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            sc1_q <= 1'b0;
            xn1_q <= '0;
            xm1_q <= '0;
            w1_q  <= '0;
        end else if (adv) begin
            v1_q  <= in_valid;
            sc1_q <= scale;
            xn1_q <= x_N;
            xm1_q <= x_M;
            w1_q  <= w_N;
        end
    end

    // Stage 2: rounded twiddle product, x_N and scale travel alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q  <= 1'b0;
            sc2_q <= 1'b0;
            xn2_q <= '0;
            pr_q  <= '0;
            pi_q  <= '0;
        end else if (adv) begin
            v2_q  <= v1_q;
            sc2_q <= sc1_q;
            xn2_q <= xn1_q;
            pr_q  <= pr_d;
            pi_q  <= pi_d;
        end
    end

    // Stage 3: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q <= 1'b0;
            yn_q <= '0;
            ym_q <= '0;
        end else if (adv) begin
            v3_q <= v2_q;
            if (v2_q) begin
                yn_q <= yn_d;
                ym_q <= ym_d;
            end
        end
    end

    // Sticky overflow: a beat overflowing on entry to S3 beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else
            ovf_q <= (adv & hit) | (ovf_q & ~ovf_clr);
    end

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// tb_fft_butterfly_pipe: vector table, corner sequences and random stream
// checked against an integer-arithmetic butterfly model.
module tb_fft_butterfly_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x_N = '0;
    logic [31:0] x_M = '0;
    logic [31:0] w_N = '0;
    logic        scale = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y_N, y_M;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fft_butterfly_pipe #(.DATA_WIDTH(32), .TW_FRAC(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_N(x_N), .x_M(x_M), .w_N(w_N), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_N(y_N), .y_M(y_M),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: one component narrowed to 16 bits, {ovf, value}.
    function automatic logic [16:0] comp_fit(input longint s);
        longint v;
        logic   o;
        o = (s > 32767) || (s < -32768);
        v = s;
`ifdef FFT_BUTTERFLY_SAT_EN
        if (s > 32767) v = 32767;
        else if (s < -32768) v = -32768;
`endif
        return {o, v[15:0]};
    endfunction

    // Reference butterfly: {ovf, y_N, y_M} from plain integer arithmetic.
    function automatic logic [64:0] ref_bfly(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] w,
                                             input logic sc);
        longint ar, ai, br, bi, wr, wi, pr, pi;
        longint s[4];
        logic [16:0] f[4];
        logic o;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        wr = longint'($signed(w[31:16]));
        wi = longint'($signed(w[15:0]));
        pr = (wr*br - wi*bi + 16384) >>> 15;
        pi = (wr*bi + wi*br + 16384) >>> 15;
        s[0] = ar + pr;
        s[1] = ai + pi;
        s[2] = ar - pr;
        s[3] = ai - pi;
        o = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sc) s[k] = s[k] >>> 1;
            f[k] = comp_fit(s[k]);
            o = o | f[k][16];
        end
        return {o, f[0][15:0], f[1][15:0], f[2][15:0], f[3][15:0]};
    endfunction

    function automatic logic [15:0] rc(input int lim);
        int r;
        r = int'($urandom_range(2*lim)) - lim;
        return r[15:0];
    endfunction

    typedef struct {
        logic [31:0] xn, xm, w;
        logic        sc;
        logic [31:0] yn, ym;
        logic        ov;
    } vec_t;

`ifdef FFT_BUTTERFLY_SAT_EN
    localparam logic [31:0] YN_POS = 32'h7FFF_0000;
    localparam logic [31:0] YN_NEG = 32'h8000_0000;
`else
    localparam logic [31:0] YN_POS = 32'hFFFD_0000;
    localparam logic [31:0] YN_NEG = 32'h0001_0000;
`endif

    vec_t        tbl[7];
    logic [64:0] q[$];
    logic        model_ovf = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] held_yn = '0;
    logic [31:0] held_ym = '0;
    int          n_out = 0;

    // Single beat into an idle pipe; checks latency, results and ovf.
    task automatic run_vec(input vec_t v, input string nm);
        int n;
        @(negedge clk);
        x_N = v.xn; x_M = v.xm; w_N = v.w; scale = v.sc;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({nm, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, 3);
        chk({nm, " y_N"}, y_N, v.yn);
        chk({nm, " y_M"}, y_M, v.ym);
        chk({nm, " ovf"}, ovf, v.ov);
    endtask

    // One streaming cycle with scoreboard, stall and ovf tracking.
    task automatic cyc(input logic iv, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] w,
                       input logic sc, input logic ordy,
                       output logic acc);
        logic [64:0] e;
        @(negedge clk);
        in_valid = iv; x_N = a; x_M = b; w_N = w;
        scale = sc; out_ready = ordy;
        #1;
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_y_N", y_N, held_yn);
            chk("hold_y_M", y_M, held_ym);
        end
        if (out_valid && !prev_stall) begin
            chk("out_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                model_ovf = model_ovf | q[0][64];
                chk("stream_ovf", ovf, model_ovf);
            end
        end
        if (out_valid && out_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("stream_y_N", y_N, e[63:32]);
            chk("stream_y_M", y_M, e[31:0]);
            n_out++;
        end
        prev_stall = out_valid && !out_ready;
        held_yn = y_N;
        held_ym = y_M;
        acc = in_valid && in_ready;
        if (acc) q.push_back(ref_bfly(a, b, w, sc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        int          bi, seen, n_acc;
        logic [31:0] sa[8], sb[8], sw[8];
        logic        ss[8];
        logic [31:0] ra, rb, rw;

        tbl[0] = '{32'h0064_0000, 32'h0032_0000, 32'h7FFF_0000, 1'b0,
                   32'h0096_0000, 32'h0032_0000, 1'b0};
        tbl[1] = '{32'h0000_0000, 32'h00C8_0000, 32'h0000_8000, 1'b0,
                   32'h0000_FF38, 32'h0000_00C8, 1'b0};
        tbl[2] = '{32'h000A_FFEC, 32'hFF9C_0040, 32'h4000_0000, 1'b0,
                   32'hFFD8_000C, 32'h003C_FFCC, 1'b0};
        tbl[3] = '{32'hFFFD_0005, 32'h0000_0000, 32'h7FFF_0000, 1'b1,
                   32'hFFFE_0002, 32'hFFFE_0002, 1'b0};
        tbl[4] = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0,
                   YN_POS, 32'h0001_0000, 1'b1};
        tbl[5] = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b1,
                   32'h7FFE_0000, 32'h0000_0000, 1'b1};
        tbl[6] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_0000, 1'b0,
                   YN_NEG, 32'hFFFF_0000, 1'b1};

        // Reset values, asserted between clock edges.
        #1 rst_n = 1'b0;
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst ovf", ovf, 0);
        chk("rst y_N", y_N, 0);
        chk("rst y_M", y_M, 0);
        chk("rst in_ready", in_ready, 1);
        #20 rst_n = 1'b1;
        #1 chk("post-rst in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset with two beats in flight and ovf set.
        @(negedge clk);
        x_N = 32'h7FFF_0000; x_M = 32'h7FFF_0000; w_N = 32'h7FFF_0000;
        scale = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre-rst ovf", ovf, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst out_valid", out_valid, 0);
        chk("mid-rst ovf", ovf, 0);
        chk("mid-rst y_N", y_N, 0);
        chk("mid-rst y_M", y_M, 0);
        chk("mid-rst in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("stale beats", seen, 0);
        run_vec(tbl[0], "after-rst");

        // Clear in the same cycle an overflowing beat enters S3.
        @(negedge clk);
        x_N = 32'h7FFF_0000; x_M = 32'h7FFF_0000; w_N = 32'h7FFF_0000;
        scale = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        chk("set-vs-clr valid", out_valid, 1);
        chk("set-vs-clr ovf", ovf, 1);
        @(negedge clk);
        chk("clr ovf", ovf, 0);
        ovf_clr = 1'b0;

        // Eight beats with downstream stalled in cycles 4-8.
        for (int i = 0; i < 8; i++) begin
            sa[i] = {rc(16384), rc(16384)};
            sb[i] = {rc(16384), rc(16384)};
            sw[i] = {rc(23170), rc(23170)};
            ss[i] = 1'($urandom_range(1));
        end
        bi = 0;
        n_out = 0;
        for (int c = 1; c <= 40 && (bi < 8 || q.size() != 0); c++) begin
            if (bi < 8)
                cyc(1'b1, sa[bi], sb[bi], sw[bi], ss[bi],
                    !(c >= 4 && c <= 8), acc);
            else
                cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
            if (acc) bi++;
        end
        chk("stall beats out", n_out, 8);

        // Random traffic and backpressure.
        n_out = 0;
        n_acc = 0;
        for (int c = 0; c < 300; c++) begin
            ra = {rc(16384), rc(16384)};
            rb = {rc(16384), rc(16384)};
            rw = {rc(23170), rc(23170)};
            cyc($urandom_range(3) != 0, ra, rb, rw,
                1'($urandom_range(1)), $urandom_range(3) != 0, acc);
            if (acc) n_acc++;
        end
        for (int c = 0; c < 50 && q.size() != 0; c++)
            cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
        chk("drain empty", q.size(), 0);
        chk("random beats out", n_out, n_acc);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
